macrocell_reg: RTL
==================

# macrocell_reg

- Parametrised register bank: successor to the single-purpose DFF/TFF/JKFF cell family.
- Provides WIDTH macrocell-style storage bits with:
  - a compile-time storage mode (D, T, JK or transparent latch);
  - clock enable and synchronous set;
  - per-bank tristate output with registered output enable.
- Sits between the product-term/XOR logic of a macrocell group and the pad buffers.
- Also supplies the internal feedback path back into the interconnect.

## Interface
- `WIDTH`, 8: number of storage bits in the bank (1..16).
- `MODE`, MC_D: storage mode from `macrocell_pkg`, one of MC_D, MC_T, MC_JK, MC_LATCH.
- `RST_VAL`, {WIDTH{1'b0}}: value loaded into Q on AR.
- `OE_RST`, 1'b0: value loaded into the registered output enable on AR.

- `CLK`, in, 1: single clock; all state changes on rising edge, except in MC_LATCH mode.
- `AR`, in, 1: **asynchronous, active-high reset.**
- `ENA`, in, 1: clock enable; when 0, Q holds.
- `SS`, in, 1: synchronous set; forces all bits to 1 on the next edge when ENA=1.
- `D`, in, WIDTH: data input; used as D (MC_D), T (MC_T), J (MC_JK) or latch data (MC_LATCH).
- `K`, in, WIDTH: K input, MC_JK only; ignored in other modes.
- `OE`, in, 1: output-enable request; registered.
- `Q`, out, WIDTH: pad-side output; high-impedance when the registered OE is 0.
- `QFB`, out, WIDTH: feedback output; always driven with the stored value.
- `OE_Q`, out, 1: current registered output enable.

## Operation
- Reset:
  - AR=1 immediately forces QFB=RST_VAL and OE_Q=OE_RST, in all modes including latch.
  - Q is RST_VAL when OE_RST=1, otherwise all-Z.
  - AR dominates ENA, SS and latch transparency.
- Priority per edge while AR=0: SS (with ENA=1) > mode update (with ENA=1) > hold.
- Mode update, per bit i:
  - MC_D: q <= D[i].
  - MC_T: q <= q ^ D[i].
  - MC_JK: 00 hold, 10 set, 01 clear, 11 toggle (J=D[i], K=K[i]).
  - MC_LATCH:
    - transparent (QFB follows D combinationally) while CLK=1 && ENA=1 && AR=0;
    - holds while CLK=0;
    - SS acts as transparent data all-ones while CLK=1 && ENA=1.
- OE register:
  - loads OE on every rising CLK edge, independent of ENA and SS;
  - in MC_LATCH mode it is still edge-triggered.
- Q = OE_Q ? QFB : all-Z; no per-bit output enable.
- Illegal MODE (outside enum): elaboration-time error.
- WIDTH outside 1..16: elaboration-time error.

## Timing
- MC_D/MC_T/MC_JK: QFB updates one cycle after the sampled inputs.
- MC_LATCH: zero-cycle flow-through while transparent.
- OE_Q: one-cycle latency from OE; Q tri-states in the same cycle that OE_Q falls.
- AR assertion: asynchronous, takes effect within the same cycle.
- AR deassertion:
  - treated as synchronous release;
  - first functional update is on the first rising edge with AR=0.
- Reset mid-operation: a T/JK toggle pending at the AR edge is discarded; state is RST_VAL.
- ENA=0 with SS=1: no set (SS is qualified by ENA).

## Structure
- `macrocell_pkg`:
  - `mc_mode_t` enum (MC_D=0, MC_T=1, MC_JK=2, MC_LATCH=3);
  - `MC_MAX_WIDTH=16`.
- Sub-module `macrocell_reg_bit`:
  - one storage bit with MODE and RST_VAL bit parameters;
  - instanced WIDTH times via generate.
- Top level holds the OE register, the tristate drive and the parameter checks.

## Test plan
- **MC_D, WIDTH=8, RST_VAL=8'hA5:**
  - AR pulse → QFB=8'hA5 immediately;
  - D=8'h3C, ENA=1 → QFB=8'h3C next edge;
  - ENA=0, D=8'hFF → QFB stays 8'h3C.
- **MC_T, RST_VAL=0:**
  - D=8'h01 held for 3 edges → QFB sequence 01, 00, 01;
  - SS=1 → QFB=8'hFF next edge.
- **MC_JK:**
  - from QFB=8'h0F, J=8'hF0, K=8'h0F → QFB=8'hF0;
  - then J=K=8'hFF → QFB=8'h0F.
- **MC_LATCH:**
  - CLK=1, ENA=1: D changes 8'h11→8'h22 → QFB tracks both values;
  - CLK falls, D=8'h33 → QFB holds 8'h22.
- **OE:**
  - OE_RST=0, OE=1 → Q all-Z until the first edge, then Q=QFB;
  - OE=0 → Q all-Z after one edge while QFB keeps updating.
- **AR mid-operation:**
  - MC_T toggling, assert AR between edges → QFB=RST_VAL and OE_Q=OE_RST at once;
  - release → toggling resumes from RST_VAL on the next edge.

Source files
------------

// File: rtl/macrocell_pkg.sv
// -----------------------------------------------------------------------------
// macrocell_pkg
// Shared types and constants for the macrocell register bank.
//   mc_mode_t    : storage mode of a bank (D, T, JK flop or transparent latch)
//   MC_MAX_WIDTH : largest legal bank width
//   mc_update    : per-bit next-state rule of the edge-triggered modes
// -----------------------------------------------------------------------------
package macrocell_pkg;

    typedef enum logic [1:0] {
        MC_D     = 2'd0,
        MC_T     = 2'd1,
        MC_JK    = 2'd2,
        MC_LATCH = 2'd3
    } mc_mode_t;

    localparam int MC_MAX_WIDTH = 16;

    // Next value of one storage bit for an enabled, non-set edge.
    // d doubles as T (MC_T) and J (MC_JK); k only matters in MC_JK.
    function automatic logic mc_update(mc_mode_t mode, logic q, logic d, logic k);
        logic nxt;
        nxt = q;
        case (mode)
            MC_D:     nxt = d;
            MC_T:     nxt = q ^ d;
            MC_JK: begin
                case ({d, k})
                    2'b00:   nxt = q;
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    default: nxt = ~q;
                endcase
            end
            default:  nxt = d;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/macrocell_reg_bit.sv
// -----------------------------------------------------------------------------
// macrocell_reg_bit
// One storage bit of the macrocell bank.
//   clk_i : clock (latch enable in MC_LATCH mode)
//   ar_i  : asynchronous active-high reset, loads RST_VAL
//   ena_i : clock / latch enable
//   ss_i  : set, qualified by ena_i
//   d_i   : D / T / J / latch data depending on MODE
//   k_i   : K input, MC_JK only
//   q_o   : stored value
// -----------------------------------------------------------------------------
module macrocell_reg_bit
    import macrocell_pkg::*;
#(
    parameter mc_mode_t MODE    = MC_D,
    parameter logic     RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic ar_i,
    input  logic ena_i,
    input  logic ss_i,
    input  logic d_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    generate
        if (MODE == MC_LATCH) begin : g_latch
            logic latch_d;
            logic unused_k;

            // While open, SS makes the latch pass an all-ones value.
            assign latch_d  = ss_i | d_i;
            assign unused_k = k_i;

            // Transparent while the clock is high and enabled; the reset
            // overrides transparency.
            always_latch begin
                if (ar_i) begin
                    q_q <= RST_VAL;
                end else if (clk_i && ena_i) begin
                    q_q <= latch_d;
                end
            end
        end else begin : g_flop
            logic q_d;

            always_comb begin
                q_d = q_q;
                if (ena_i) begin
                    q_d = ss_i ? 1'b1 : mc_update(MODE, q_q, d_i, k_i);
                end
            end

            // A toggle pending when AR rises is simply lost: the reset
            // branch wins and the next edge starts from RST_VAL.
            always_ff @(posedge clk_i or posedge ar_i) begin
                if (ar_i) begin
                    q_q <= RST_VAL;
                end else begin
                    q_q <= q_d;
                end
            end
        end
    endgenerate

    assign q_o = q_q;

endmodule

// File: rtl/macrocell_reg.sv
// -----------------------------------------------------------------------------
// macrocell_reg
// Bank of WIDTH macrocell storage bits with registered, bank-wide output
// enable and tristate pad drive.
//   CLK  : clock
//   AR   : asynchronous active-high reset (Q bits -> RST_VAL, OE_Q -> OE_RST)
//   ENA  : clock enable for the storage bits (not for the OE register)
//   SS   : set all bits, qualified by ENA
//   D    : D / T / J / latch data, K : K input (MC_JK only)
//   OE   : output-enable request, registered every rising edge
//   Q    : pad output, all-Z while OE_Q is 0
//   QFB  : feedback output, always the stored value
//   OE_Q : registered output enable
// -----------------------------------------------------------------------------
module macrocell_reg
    import macrocell_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter mc_mode_t         MODE    = MC_D,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter logic             OE_RST  = 1'b0
) (
    input  logic             CLK,
    input  logic             AR,
    input  logic             ENA,
    input  logic             SS,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] K,
    input  logic             OE,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QFB,
    output logic             OE_Q
);

    generate
        if (WIDTH < 1 || WIDTH > MC_MAX_WIDTH) begin : g_bad_width
            $error("macrocell_reg: WIDTH %0d outside 1..%0d", WIDTH, MC_MAX_WIDTH);
        end
        if (MODE != MC_D && MODE != MC_T && MODE != MC_JK && MODE != MC_LATCH) begin : g_bad_mode
            $error("macrocell_reg: illegal MODE %0d", MODE);
        end
    endgenerate

    // Output enable stays edge-triggered even for a latch bank, and ignores
    // ENA/SS so the pads can be turned around while the data is frozen.
    logic oe_q;
    logic oe_d;

    assign oe_d = OE;

    always_ff @(posedge CLK or posedge AR) begin
        if (AR) begin
            oe_q <= OE_RST;
        end else begin
            oe_q <= oe_d;
        end
    end

    logic [WIDTH-1:0] qfb_w;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            macrocell_reg_bit #(
                .MODE    (MODE),
                .RST_VAL (RST_VAL[gi])
            ) u_bit (
                .clk_i (CLK),
                .ar_i  (AR),
                .ena_i (ENA),
                .ss_i  (SS),
                .d_i   (D[gi]),
                .k_i   (K[gi]),
                .q_o   (qfb_w[gi])
            );
        end
    endgenerate

    assign QFB  = qfb_w;
    assign OE_Q = oe_q;
    assign Q    = oe_q ? qfb_w : {WIDTH{1'bz}};

endmodule
